tpmem_ctrl: RTL and testbench



---
 rtl/tpmem_ctrl.sv | 125 ++++++++++++
 tb/tb_tpmem_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpmem_ctrl.sv
// tpmem_ctrl: row scheduler in front of the 8x8 transpose memory.
// Buffers upstream rows in a small FIFO and drives the transpose memory
// write-enable so that blocks are only ever written whole. The 4-bit shadow
// counter tracks the transpose memory's own counter: FILL while cnt[3]=0,
// DRAIN for the 8 cycles with cnt[3]=1. A full block buffered at cnt==8 is
// written column-wise during DRAIN (burst), overlapping the previous output.
module tpmem_ctrl #(
    parameter int BW    = 11,
    parameter int DEPTH = 16
) (
    input  logic            i_clk,
    input  logic            i_Reset,
    input  logic [8*BW-1:0] i_data,
    input  logic            i_valid,
    output logic            o_ready,
    output logic [8*BW-1:0] o_tp_data,
    output logic            o_tp_en,
    output logic            o_out_first,
    output logic            o_out_last,
    output logic [15:0]     o_blk_cnt,
    output logic            o_busy
);

    localparam int            AW       = $clog2(DEPTH);
    localparam int            CW       = AW + 1;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [CW-1:0] BLK_ROWS = CW'(8);

    logic [8*BW-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [3:0]      cnt;
    logic            burst_r;
    logic            push;
    logic            pop;
    logic            cnt_is8;
    logic            cnt_is15;
    logic            have_block;

    assign o_ready    = (count != FULL);
    assign push       = i_valid && o_ready;
    assign pop        = o_tp_en;
    assign cnt_is8    = (cnt == 4'd8);
    assign cnt_is15   = (cnt == 4'd15);
    assign have_block = (count >= BLK_ROWS);
    assign o_busy     = (count != '0) || (cnt != 4'd0);

    // An empty FIFO presents zero so the data bus is clean in and after reset.
    assign o_tp_data  = (count != '0) ? mem[rd_ptr] : '0;

    // Enable depends on registered state only: FILL issues any buffered row,
    // cnt==8 decides the burst, and the rest of DRAIN follows that decision.
    always_comb begin
        o_tp_en = 1'b0;
        if (!cnt[3]) begin
            o_tp_en = (count != '0);
        end else if (cnt_is8) begin
            o_tp_en = have_block;
        end else begin
            o_tp_en = burst_r;
        end
    end

    // Row storage; contents need no reset because the pointers and count do.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop keeps count.
    always_ff @(posedge i_clk or negedge i_Reset) begin
        if (!i_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Shadow counter and burst flag, mirroring the transpose memory counter.
    always_ff @(posedge i_clk or negedge i_Reset) begin
        if (!i_Reset) begin
            cnt     <= 4'd0;
            burst_r <= 1'b0;
        end else begin
            if (o_tp_en || cnt[3]) begin
                cnt <= cnt + 4'd1;
            end
            if (cnt_is8 && have_block) begin
                burst_r <= 1'b1;
            end else if (cnt_is15) begin
                burst_r <= 1'b0;
            end
        end
    end

    // Framing pulses land one cycle after cnt==8 / cnt==15, matching the memory output.
    always_ff @(posedge i_clk or negedge i_Reset) begin
        if (!i_Reset) begin
            o_out_first <= 1'b0;
            o_out_last  <= 1'b0;
            o_blk_cnt   <= 16'd0;
        end else begin
            o_out_first <= cnt_is8;
            o_out_last  <= cnt_is15;
            if (cnt_is15) begin
                o_blk_cnt <= o_blk_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tpmem_ctrl.sv
// tb_tpmem_ctrl: directed bench for tpmem_ctrl. Instance A (DEPTH=16) covers
// single blocks, bursts, partial blocks, gapped input and reset mid-burst;
// instance B (DEPTH=8) covers back-pressure with valid held high.
module tb_tpmem_ctrl;

    localparam int BW = 11;
    localparam int RW = 8 * BW;

    logic          i_clk = 1'b0;

    logic          a_reset;
    logic [RW-1:0] a_data;
    logic          a_valid;
    logic          a_ready;
    logic [RW-1:0] a_tp_data;
    logic          a_tp_en;
    logic          a_first;
    logic          a_last;
    logic [15:0]   a_blk;
    logic          a_busy;

    logic          b_reset;
    logic [RW-1:0] b_data;
    logic          b_valid;
    logic          b_ready;
    logic [RW-1:0] b_tp_data;
    logic          b_tp_en;
    logic          b_first;
    logic          b_last;
    logic [15:0]   b_blk;
    logic          b_busy;

    int            checks   = 0;
    int            failures = 0;
    logic [RW-1:0] sb [$];

    tpmem_ctrl #(.BW(BW), .DEPTH(16)) dut_a (
        .i_clk       (i_clk),
        .i_Reset     (a_reset),
        .i_data      (a_data),
        .i_valid     (a_valid),
        .o_ready     (a_ready),
        .o_tp_data   (a_tp_data),
        .o_tp_en     (a_tp_en),
        .o_out_first (a_first),
        .o_out_last  (a_last),
        .o_blk_cnt   (a_blk),
        .o_busy      (a_busy)
    );

    tpmem_ctrl #(.BW(BW), .DEPTH(8)) dut_b (
        .i_clk       (i_clk),
        .i_Reset     (b_reset),
        .i_data      (b_data),
        .i_valid     (b_valid),
        .o_ready     (b_ready),
        .o_tp_data   (b_tp_data),
        .o_tp_en     (b_tp_en),
        .o_out_first (b_first),
        .o_out_last  (b_last),
        .o_blk_cnt   (b_blk),
        .o_busy      (b_busy)
    );

    always #5 i_clk = ~i_clk;

    // Distinct row pattern: coefficient j of row k is k*8+j.
    function automatic logic [RW-1:0] make_row(input int k);
        logic [RW-1:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            r[j*BW +: BW] = BW'(k * 8 + j);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_a_reset(input string tag);
        check_output({tag, "_tp_en"},   a_tp_en,   1'b0);
        check_output({tag, "_first"},   a_first,   1'b0);
        check_output({tag, "_last"},    a_last,    1'b0);
        check_output({tag, "_blk"},     a_blk,     16'd0);
        check_output({tag, "_busy"},    a_busy,    1'b0);
        check_output({tag, "_tp_data"}, a_tp_data, '0);
        check_output({tag, "_ready"},   a_ready,   1'b1);
    endtask

    // Scoreboard step for instance B: compare the head about to be written.
    task automatic apply_stimulus_b_pop(input string tag);
        if (b_tp_en) begin
            if (sb.size() != 0) begin
                check_output(tag, b_tp_data, sb[0]);
                void'(sb.pop_front());
            end else begin
                check_output({tag, "_underflow"}, b_tp_en, 1'b0);
            end
        end
    endtask

    initial begin
        int   next_idx;
        logic accept;

        $display("[TB] start");
        a_reset = 1'b0;
        b_reset = 1'b0;
        a_valid = 1'b1;
        a_data  = make_row(999);
        b_valid = 1'b0;
        b_data  = '0;

        // Reset state, with valid asserted so any push during reset would show.
        repeat (3) tick();
        check_a_reset("rst_hold");
        a_reset = 1'b1;
        b_reset = 1'b1;
        a_valid = 1'b0;
        tick();
        check_output("rst_release_busy", a_busy, 1'b0);
        check_output("rst_release_en",   a_tp_en, 1'b0);

        // One block of 8 back-to-back rows, then an 8-cycle drain with no issue.
        $display("[TB] single block");
        for (int k = 0; k < 8; k++) begin
            a_valid = 1'b1;
            a_data  = make_row(k);
            tick();
            check_output($sformatf("t1_en_%0d", k),   a_tp_en,   1'b1);
            check_output($sformatf("t1_data_%0d", k), a_tp_data, make_row(k));
        end
        a_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_output($sformatf("t1_drain_en_%0d", k), a_tp_en, 1'b0);
            check_output($sformatf("t1_first_%0d", k),    a_first, 1'(k == 1));
            check_output($sformatf("t1_last_%0d", k),     a_last,  1'b0);
            check_output($sformatf("t1_busy_%0d", k),     a_busy,  1'b1);
        end
        tick();
        check_output("t1_end_last",  a_last,  1'b1);
        check_output("t1_end_first", a_first, 1'b0);
        check_output("t1_end_blk",   a_blk,   16'd1);
        check_output("t1_end_busy",  a_busy,  1'b0);
        check_output("t1_end_en",    a_tp_en, 1'b0);

        // 24 continuous rows: block 2 fills during block 1 drain, so a burst is
        // taken at cnt==8 and enable stays high for 16 consecutive cycles.
        $display("[TB] burst");
        for (int m = 0; m < 24; m++) begin
            a_valid = 1'b1;
            a_data  = make_row(100 + m);
            tick();
            if (m < 8) begin
                check_output($sformatf("t2_en_%0d", m),   a_tp_en,   1'b1);
                check_output($sformatf("t2_data_%0d", m), a_tp_data, make_row(100 + m));
            end else if (m < 16) begin
                check_output($sformatf("t2_en_%0d", m),    a_tp_en, 1'b0);
                check_output($sformatf("t2_ready_%0d", m), a_ready, 1'b1);
            end else begin
                check_output($sformatf("t2_en_%0d", m),   a_tp_en,   1'b1);
                check_output($sformatf("t2_data_%0d", m), a_tp_data, make_row(100 + m - 8));
            end
            if (m == 9) begin
                check_output("t2_first_a", a_first, 1'b1);
            end
            if (m == 16) begin
                check_output("t2_last_a", a_last, 1'b1);
                check_output("t2_blk_a",  a_blk,  16'd2);
            end
        end
        a_valid = 1'b0;
        for (int m = 0; m < 8; m++) begin
            tick();
            check_output($sformatf("t2_burst_en_%0d", m),   a_tp_en,   1'b1);
            check_output($sformatf("t2_burst_data_%0d", m), a_tp_data, make_row(116 + m));
            check_output($sformatf("t2_burst_first_%0d", m), a_first,  1'(m == 1));
        end
        tick();
        check_output("t2_end_en",   a_tp_en, 1'b0);
        check_output("t2_end_last", a_last,  1'b1);
        check_output("t2_end_blk",  a_blk,   16'd3);
        check_output("t2_end_busy", a_busy,  1'b0);

        // 8 rows, then 5 rows arriving during DRAIN: no partial burst.
        $display("[TB] partial block");
        for (int m = 0; m < 8; m++) begin
            a_valid = 1'b1;
            a_data  = make_row(200 + m);
            tick();
            check_output($sformatf("t3_en_%0d", m),   a_tp_en,   1'b1);
            check_output($sformatf("t3_data_%0d", m), a_tp_data, make_row(200 + m));
        end
        for (int m = 0; m < 8; m++) begin
            a_valid = (m < 5);
            a_data  = make_row(208 + m);
            tick();
            check_output($sformatf("t3_drain_en_%0d", m), a_tp_en, 1'b0);
        end
        a_valid = 1'b0;
        tick();
        check_output("t3_last", a_last,    1'b1);
        check_output("t3_blk",  a_blk,     16'd4);
        check_output("t3_en_r0",   a_tp_en,   1'b1);
        check_output("t3_data_r0", a_tp_data, make_row(208));
        for (int m = 1; m < 5; m++) begin
            tick();
            check_output($sformatf("t3_fill_en_%0d", m),   a_tp_en,   1'b1);
            check_output($sformatf("t3_fill_data_%0d", m), a_tp_data, make_row(208 + m));
        end
        tick();
        check_output("t3_hold_en",   a_tp_en, 1'b0);
        check_output("t3_hold_busy", a_busy,  1'b1);
        repeat (3) tick();
        check_output("t3_hold2_en",    a_tp_en, 1'b0);
        check_output("t3_hold2_busy",  a_busy,  1'b1);
        check_output("t3_hold2_first", a_first, 1'b0);

        // Asynchronous reset clears the stuck partial block at once.
        a_reset = 1'b0;
        #1;
        check_a_reset("t4_rst");
        tick();
        a_reset = 1'b1;
        tick();

        // Gapped input, one row every third cycle: single-cycle enable pulses.
        $display("[TB] gapped input");
        for (int k = 0; k < 8; k++) begin
            a_valid = 1'b1;
            a_data  = make_row(400 + k);
            tick();
            check_output($sformatf("t4_en_%0d", k),    a_tp_en,   1'b1);
            check_output($sformatf("t4_data_%0d", k),  a_tp_data, make_row(400 + k));
            check_output($sformatf("t4_first_%0d", k), a_first,   1'b0);
            a_valid = 1'b0;
            tick();
            check_output($sformatf("t4_gap1_en_%0d", k), a_tp_en, 1'b0);
            check_output($sformatf("t4_gap1_first_%0d", k), a_first, 1'b0);
            tick();
            check_output($sformatf("t4_gap2_en_%0d", k), a_tp_en, 1'b0);
            check_output($sformatf("t4_gap2_first_%0d", k), a_first, 1'(k == 7));
        end
        repeat (6) tick();
        check_output("t4_pre_last", a_last, 1'b0);
        tick();
        check_output("t4_last", a_last, 1'b1);
        check_output("t4_blk",  a_blk,  16'd1);
        check_output("t4_busy", a_busy, 1'b0);

        // Reset asserted at cnt==11 in the middle of a burst.
        $display("[TB] reset mid-burst");
        for (int m = 0; m < 24; m++) begin
            a_valid = 1'b1;
            a_data  = make_row(500 + m);
            tick();
        end
        a_valid = 1'b0;
        repeat (4) tick();
        check_output("t5_burst_en",   a_tp_en,   1'b1);
        check_output("t5_burst_data", a_tp_data, make_row(519));
        check_output("t5_burst_blk",  a_blk,     16'd2);
        a_reset = 1'b0;
        #1;
        check_a_reset("t5_rst");
        tick();
        a_reset = 1'b1;
        tick();
        check_output("t5_post_busy", a_busy, 1'b0);
        for (int k = 0; k < 8; k++) begin
            a_valid = 1'b1;
            a_data  = make_row(600 + k);
            tick();
            check_output($sformatf("t5_en_%0d", k),   a_tp_en,   1'b1);
            check_output($sformatf("t5_data_%0d", k), a_tp_data, make_row(600 + k));
        end
        a_valid = 1'b0;
        repeat (8) tick();
        tick();
        check_output("t5_last", a_last, 1'b1);
        check_output("t5_blk",  a_blk,  16'd1);
        check_output("t5_busy", a_busy, 1'b0);

        // DEPTH=8 with valid held high: back-pressure and scoreboard ordering.
        $display("[TB] depth 8 back-pressure");
        next_idx = 0;
        for (int c = 0; c < 34; c++) begin
            b_valid = 1'b1;
            b_data  = make_row(700 + next_idx);
            accept  = b_ready;
            apply_stimulus_b_pop($sformatf("b_data_%0d", c));
            if (accept) begin
                sb.push_back(b_data);
                next_idx++;
            end
            tick();
            case (c + 1)
                15: check_output("b_ready_15", b_ready, 1'b1);
                16: check_output("b_ready_16", b_ready, 1'b0);
                17: check_output("b_ready_17", b_ready, 1'b0);
                18: check_output("b_ready_18", b_ready, 1'b1);
                25: check_output("b_ready_25", b_ready, 1'b1);
                26: check_output("b_ready_26", b_ready, 1'b0);
                default: ;
            endcase
        end
        b_valid = 1'b0;
        check_output("b_pushed", next_idx, 24);
        for (int c = 0; c < 40 && sb.size() != 0; c++) begin
            apply_stimulus_b_pop($sformatf("b_drain_%0d", c));
            tick();
        end
        check_output("b_sb_empty", sb.size(), 0);
        repeat (10) tick();
        check_output("b_busy", b_busy, 1'b0);
        check_output("b_blk",  b_blk,  16'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
